explosion_manager: RTL and testbench

Downstream consumer of the bomb stage's explosion events. It captures each `explosion_write_enable` pulse with its `exploding_bomb_x/y` into one of several concurrent flame slots. Each slot is drawn as a cross-shaped flame, clipped to the arena, for a fixed number of clocks. Per pixel it reports whether the current VGA pixel is inside any live flame, and whether the bomberman's 16x16 box touches one.

---
 rtl/explosion_manager.sv | 132 +++++++++++++
 tb/tb_explosion_manager.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/explosion_manager.sv
// Tracks up to NUM_SLOTS concurrent cross-shaped flames and tests the current
// VGA pixel and the bomberman's 16x16 box against every live flame.
module explosion_manager #(
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int          TILE            = 16,
  parameter int          ARM_LEN         = 2,
  parameter int          EXPLOSION_TICKS = 50000000,
  parameter int          X_MIN           = 0,
  parameter int          X_MAX           = 639,
  parameter int          Y_MIN           = 0,
  parameter int          Y_MAX           = 479
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       explosion_write_enable,
  input  logic [9:0] exploding_bomb_x,
  input  logic [9:0] exploding_bomb_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  output logic       explosion_on,
  output logic       player_hit,
  output logic [2:0] active_count,
  output logic       overflow
);

  localparam int          ARM        = ARM_LEN * TILE;
  localparam logic [31:0] TIMER_INIT = 32'(EXPLOSION_TICKS - 1);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Inclusive 2-D overlap of [ax0,ax1]x[ay0,ay1] and [bx0,bx1]x[by0,by1].
  function automatic logic overlap(input int ax0, input int ax1, input int ay0, input int ay1,
                                   input int bx0, input int bx1, input int by0, input int by1);
    return (ax0 <= bx1) && (bx0 <= ax1) && (ay0 <= by1) && (by0 <= ay1);
  endfunction

  logic [NUM_SLOTS-1:0] live;
  logic [9:0]           cx    [NUM_SLOTS];
  logic [9:0]           cy    [NUM_SLOTS];
  logic [9:0]           l     [NUM_SLOTS];
  logic [9:0]           r     [NUM_SLOTS];
  logic [9:0]           t     [NUM_SLOTS];
  logic [9:0]           b     [NUM_SLOTS];
  logic [31:0]          timer [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] grant;
  logic                 free_found;
  logic [9:0]           new_l, new_r, new_t, new_b;
  logic                 pix_hit, box_hit;
  logic [2:0]           live_count;

  // Computed in int so cx-ARM below zero clamps instead of wrapping.
  assign new_l = 10'(imax(int'(exploding_bomb_x) - ARM, X_MIN));
  assign new_r = 10'(imin(int'(exploding_bomb_x) + ARM + TILE - 1, X_MAX));
  assign new_t = 10'(imax(int'(exploding_bomb_y) - ARM, Y_MIN));
  assign new_b = 10'(imin(int'(exploding_bomb_y) + ARM + TILE - 1, Y_MAX));

  always_comb begin
    grant      = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!live[i] && !free_found) begin
        grant[i]   = explosion_write_enable;
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    pix_hit    = 1'b0;
    box_hit    = 1'b0;
    live_count = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (live[i]) begin
        live_count = live_count + 3'(live[i]);
        if (overlap(int'(l[i]), int'(r[i]), int'(cy[i]), imin(int'(cy[i]) + TILE - 1, Y_MAX),
                    int'(v_x), int'(v_x), int'(v_y), int'(v_y)) ||
            overlap(imax(int'(cx[i]), X_MIN), imin(int'(cx[i]) + TILE - 1, X_MAX),
                    int'(t[i]), int'(b[i]),
                    int'(v_x), int'(v_x), int'(v_y), int'(v_y)))
          pix_hit = 1'b1;
        if (overlap(int'(l[i]), int'(r[i]), int'(cy[i]), imin(int'(cy[i]) + TILE - 1, Y_MAX),
                    int'(b_x), int'(b_x) + TILE - 1, int'(b_y), int'(b_y) + TILE - 1) ||
            overlap(imax(int'(cx[i]), X_MIN), imin(int'(cx[i]) + TILE - 1, X_MAX),
                    int'(t[i]), int'(b[i]),
                    int'(b_x), int'(b_x) + TILE - 1, int'(b_y), int'(b_y) + TILE - 1))
          box_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live         <= '0;
      explosion_on <= 1'b0;
      player_hit   <= 1'b0;
      active_count <= '0;
      overflow     <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) timer[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        // grant only targets slots that were not live, so no conflict with expiry.
        if (grant[i]) begin
          live[i]  <= 1'b1;
          timer[i] <= TIMER_INIT;
          cx[i]    <= exploding_bomb_x;
          cy[i]    <= exploding_bomb_y;
          l[i]     <= new_l;
          r[i]     <= new_r;
          t[i]     <= new_t;
          b[i]     <= new_b;
        end else if (live[i]) begin
          if (timer[i] == '0) live[i] <= 1'b0;
          else                timer[i] <= timer[i] - 32'd1;
        end
      end
      explosion_on <= pix_hit;
      player_hit   <= box_hit;
      active_count <= live_count;
      overflow     <= explosion_write_enable && !free_found;
    end
  end

endmodule

// File: tb/tb_explosion_manager.sv
// Randomised and directed checks of explosion_manager against a slot model
// that tracks each flame by its allocation edge and lifetime.
module tb_explosion_manager;

  localparam int TICKS = 100;
  localparam int NS    = 4;
  localparam int TL    = 16;
  localparam int ARMP  = 32;
  localparam int XMAX  = 639;
  localparam int YMAX  = 479;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       we = 1'b0;
  logic [9:0] ex = '0, ey = '0, vx = '0, vy = '0, bx = '0, by = '0;
  logic       explosion_on, player_hit, overflow;
  logic [2:0] active_count;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  bit m_valid [NS];
  int m_alloc [NS];
  int m_cx    [NS];
  int m_cy    [NS];

  logic       exp_on, exp_hit, exp_ovf;
  logic [2:0] exp_cnt;

  explosion_manager #(
    .NUM_SLOTS(NS), .TILE(TL), .ARM_LEN(2), .EXPLOSION_TICKS(TICKS),
    .X_MIN(0), .X_MAX(XMAX), .Y_MIN(0), .Y_MAX(YMAX)
  ) dut (
    .clk(clk), .reset(reset), .explosion_write_enable(we),
    .exploding_bomb_x(ex), .exploding_bomb_y(ey),
    .v_x(vx), .v_y(vy), .b_x(bx), .b_y(by),
    .explosion_on(explosion_on), .player_hit(player_hit),
    .active_count(active_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit rect_hit(input int ax0, input int ax1, input int ay0, input int ay1,
                                  input int bx0, input int bx1, input int by0, input int by1);
    return ax0 <= bx1 && bx0 <= ax1 && ay0 <= by1 && by0 <= ay1;
  endfunction

  // Does box [x0,x1]x[y0,y1] touch the cross centred on tile (c_x,c_y)?
  function automatic bit cross_hit(input int c_x, input int c_y,
                                   input int x0, input int x1, input int y0, input int y1);
    bit h, v;
    h = rect_hit(imax(c_x - ARMP, 0), imin(c_x + ARMP + TL - 1, XMAX),
                 c_y, imin(c_y + TL - 1, YMAX), x0, x1, y0, y1);
    v = rect_hit(c_x, imin(c_x + TL - 1, XMAX),
                 imax(c_y - ARMP, 0), imin(c_y + ARMP + TL - 1, YMAX), x0, x1, y0, y1);
    return h || v;
  endfunction

  // A slot allocated at edge A is live after edges A .. A+TICKS-1.
  function automatic bit m_live(input int i, input int e);
    return m_valid[i] && e >= m_alloc[i] && (e - m_alloc[i]) < TICKS;
  endfunction

  task automatic step();
    int e, slot;
    e = edge_n;
    exp_on = 1'b0; exp_hit = 1'b0; exp_ovf = 1'b0; exp_cnt = '0;
    if (reset) begin
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (m_live(i, e)) begin
          exp_cnt++;
          if (cross_hit(m_cx[i], m_cy[i], int'(vx), int'(vx), int'(vy), int'(vy))) exp_on = 1'b1;
          if (cross_hit(m_cx[i], m_cy[i], int'(bx), int'(bx) + 15, int'(by), int'(by) + 15)) exp_hit = 1'b1;
        end
      end
      if (we) begin
        slot = -1;
        for (int i = 0; i < NS; i++) if (slot < 0 && !m_live(i, e)) slot = i;
        if (slot < 0) exp_ovf = 1'b1;
        else begin
          m_valid[slot] = 1'b1; m_alloc[slot] = e + 1;
          m_cx[slot] = int'(ex); m_cy[slot] = int'(ey);
        end
      end
    end
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; we = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic strobe(input int x, input int y);
    we = 1'b1; ex = 10'(x); ey = 10'(y);
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; we = 1'b1; ex = 10'd100; ey = 10'd100;
    step();
    step();
    total++; if (explosion_on !== 1'b0) begin bad++; $display("FAIL reset_on got=%b want=0", explosion_on); end
    total++; if (player_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", player_hit); end
    total++; if (active_count !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", active_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    reset = 1'b0; we = 1'b0;
    step();
    total++; if (active_count !== 3'd0) begin bad++; $display("FAIL reset_strobe_stored cnt=%0d want=0", active_count); end
  endtask

  task automatic test_cross();
    int px [5] = '{288, 351, 320, 287, 300};
    int py [5] = '{240, 255, 208, 240, 230};
    bit req [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int a;
    do_reset();
    strobe(320, 240);
    a = edge_n;
    for (int k = 0; k < 5; k++) begin
      vx = 10'(px[k]); vy = 10'(py[k]);
      step();
      total++;
      if (explosion_on !== req[k]) begin
        bad++; $display("FAIL cross_pix(%0d,%0d) got=%b want=%b", px[k], py[k], explosion_on, req[k]);
      end
    end
    vx = 10'd320; vy = 10'd240;
    while (edge_n < a + TICKS + 2) begin
      step();
      total++;
      if (explosion_on !== exp_on || active_count !== exp_cnt) begin
        bad++; $display("FAIL cross_life edge+%0d on=%b/%b cnt=%0d/%0d", edge_n - a,
                        explosion_on, exp_on, active_count, exp_cnt);
      end
    end
    total++; if (explosion_on !== 1'b0) begin bad++; $display("FAIL cross_gone got=%b want=0", explosion_on); end
  endtask

  task automatic test_corner();
    int px [7] = '{47, 48, 639, 0, 0, 15, 16};
    int py [7] = '{0, 0, 479, 47, 48, 47, 47};
    bit req [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    strobe(0, 0);
    for (int k = 0; k < 7; k++) begin
      vx = 10'(px[k]); vy = 10'(py[k]);
      step();
      total++;
      if (explosion_on !== req[k]) begin
        bad++; $display("FAIL corner_pix(%0d,%0d) got=%b want=%b", px[k], py[k], explosion_on, req[k]);
      end
    end
    for (int k = 0; k < 60; k++) begin
      vx = (k % 2 == 0) ? 10'($urandom_range(0, 80)) : 10'($urandom_range(0, 1023));
      vy = (k % 3 == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 80));
      step();
      total++;
      if (explosion_on !== exp_on) begin
        bad++; $display("FAIL corner_rand(%0d,%0d) got=%b want=%b", vx, vy, explosion_on, exp_on);
      end
    end
  endtask

  task automatic test_player();
    do_reset();
    strobe(320, 240);
    bx = 10'd330; by = 10'd270;
    step();
    total++; if (player_hit !== 1'b1) begin bad++; $display("FAIL player_arm got=%b want=1", player_hit); end
    bx = 10'd340; by = 10'd260;
    step();
    total++; if (player_hit !== 1'b0) begin bad++; $display("FAIL player_gap got=%b want=0", player_hit); end
    for (int k = 0; k < 80; k++) begin
      bx = 10'(260 + $urandom_range(0, 120)); by = 10'(180 + $urandom_range(0, 120));
      step();
      total++;
      if (player_hit !== exp_hit) begin
        bad++; $display("FAIL player_rand(%0d,%0d) got=%b want=%b", bx, by, player_hit, exp_hit);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      strobe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
      total++;
      if (overflow !== (k == 4)) begin
        bad++; $display("FAIL b2b_ovf strobe=%0d got=%b want=%b", k, overflow, (k == 4));
      end
    end
    step();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf_sticky got=%b want=0", overflow); end
    total++; if (active_count !== 3'd4) begin bad++; $display("FAIL b2b_cnt got=%0d want=4", active_count); end
  endtask

  task automatic test_expiry_collision();
    int t0;
    do_reset();
    strobe(100, 100); t0 = edge_n;
    strobe(200, 100); strobe(300, 100); strobe(400, 100);
    while (edge_n + 1 < t0 + TICKS) step();
    strobe(500, 300);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL expiry_full_ovf got=%b want=1", overflow); end
    step();
    total++; if (active_count !== 3'd3) begin bad++; $display("FAIL expiry_full_cnt got=%0d want=3", active_count); end

    do_reset();
    strobe(100, 100); t0 = edge_n;
    strobe(200, 100); strobe(300, 100);
    while (edge_n + 1 < t0 + TICKS) step();
    strobe(500, 300);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL expiry_free_ovf got=%b want=0", overflow); end
    vx = 10'd500; vy = 10'd300;
    step();
    total++; if (explosion_on !== 1'b1) begin bad++; $display("FAIL expiry_free_on got=%b want=1", explosion_on); end
    total++; if (active_count !== 3'd3) begin bad++; $display("FAIL expiry_free_cnt got=%0d want=3", active_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    strobe(320, 240); strobe(100, 100); strobe(500, 400);
    vx = 10'd320; vy = 10'd240; bx = 10'd330; by = 10'd270;
    step();
    total++; if (explosion_on !== 1'b1 || player_hit !== 1'b1) begin
      bad++; $display("FAIL midreset_pre on=%b hit=%b want=1/1", explosion_on, player_hit);
    end
    reset = 1'b1; we = 1'b1; ex = 10'd320; ey = 10'd240;
    step();
    total++; if ({explosion_on, player_hit, active_count, overflow} !== 6'd0) begin
      bad++; $display("FAIL midreset_outs on=%b hit=%b cnt=%0d ovf=%b want all 0",
                      explosion_on, player_hit, active_count, overflow);
    end
    reset = 1'b0; we = 1'b0;
    step();
    total++; if (active_count !== 3'd0 || explosion_on !== 1'b0) begin
      bad++; $display("FAIL midreset_post cnt=%0d on=%b want 0/0", active_count, explosion_on);
    end
  endtask

  task automatic test_random();
    int lx = 320, ly = 240;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 399) == 0);
      we = ($urandom_range(0, 29) == 0) || (k % 250 < 6);
      if (we) begin
        ex = 10'($urandom_range(0, 1023)); ey = 10'($urandom_range(0, 1023));
        lx = int'(ex); ly = int'(ey);
      end
      vx = 10'(lx + int'($urandom_range(0, 111)) - 48);
      vy = 10'(ly + int'($urandom_range(0, 111)) - 48);
      bx = 10'(lx + int'($urandom_range(0, 111)) - 56);
      by = 10'(ly + int'($urandom_range(0, 111)) - 56);
      step();
      total++;
      if (explosion_on !== exp_on || player_hit !== exp_hit ||
          active_count !== exp_cnt || overflow !== exp_ovf) begin
        bad++;
        $display("FAIL random edge=%0d on=%b/%b hit=%b/%b cnt=%0d/%0d ovf=%b/%b", edge_n,
                 explosion_on, exp_on, player_hit, exp_hit, active_count, exp_cnt, overflow, exp_ovf);
      end
    end
    reset = 1'b0; we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0; m_alloc[i] = 0; m_cx[i] = 0; m_cy[i] = 0;
    end
    #2;
    test_reset();
    test_cross();
    test_corner();
    test_player();
    test_back_to_back();
    test_expiry_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
